// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 responder.
//  SPI_BITS      : frame byte width
//  state_t       : FSM encoding (ST_IDLE, ST_ACTIVE)
//  FILL_BYTE_DEF : default byte shifted out on TX underrun
package spi_pkg;
  localparam int SPI_BITS = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [SPI_BITS-1:0] FILL_BYTE_DEF = 8'hFF;
endpackage

// File: rtl/spi_sync.sv
// Pin synchroniser with edge detect.
//  clk, reset : system clock, synchronous active-high reset
//  pin_i      : asynchronous input pin
//  rise_o     : 1 for one cycle when the synchronised level goes 0->1
//  fall_o     : 1 for one cycle when the synchronised level goes 1->0
// STAGES flops bring the pin into the clk domain; one more flop holds the
// previous synchronised level for edge detection. All flops reset to RST_VAL
// (the idle level of the pin) so reset itself produces no edge.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) in the system clock domain.
//  clk, reset  : system clock, synchronous active-high reset
//  spi_clk/spi_ss_n/spi_di : pins from the external master (asynchronous)
//  spi_do, spi_do_en       : MISO data and output enable
//  rx_strobe/rx_data/rx_first : received byte, strobe, first-of-frame flag
//  tx_strobe/tx_din        : write the one-byte TX holding register
//  tx_pending, tx_underrun : holding reg full / shifter loaded FILL_BYTE
//  active, frame_end       : frame in progress / end-of-frame pulse
module spi_slave
  import spi_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0]  FILL_BYTE   = FILL_BYTE_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_clk,
  input  logic                spi_ss_n,
  input  logic                spi_di,
  output logic                spi_do,
  output logic                spi_do_en,
  output logic                rx_strobe,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_first,
  input  logic                tx_strobe,
  input  logic [SPI_BITS-1:0] tx_din,
  output logic                tx_pending,
  output logic                tx_underrun,
  output logic                active,
  output logic                frame_end
);
  logic sck_rise, sck_fall, ss_rise, ss_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .pin_i(spi_clk), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .reset(reset), .pin_i(spi_ss_n), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic                first_q, first_d;
  logic                reload_q, reload_d;
  logic [SPI_BITS-2:0] rx_shift_q, rx_shift_d;
  logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic                rx_strobe_q, rx_strobe_d;
  logic                rx_first_q, rx_first_d;
  logic [SPI_BITS-1:0] tx_hold_q, tx_hold_d;
  logic                tx_pending_q, tx_pending_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic [SPI_BITS-1:0] shift_q, shift_d;
  logic                frame_end_q, frame_end_d;
  logic [SYNC_STAGES-1:0] di_q, di_d;
  // settle_q fills with ones after reset; once the top bit is set every
  // ss_n sync flop holds a real pin sample, so a falling edge is genuine
  // and not an artefact of the idle-level preset. This forces a frame that
  // was cut by reset to be re-opened by a fresh ss_n high->low.
  logic [SYNC_STAGES:0]   settle_q, settle_d;
  logic                   load;
  logic                   di_s;

  assign di_s = di_q[SYNC_STAGES-1];

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    first_d       = first_q;
    reload_d      = reload_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_strobe_d   = 1'b0;
    rx_first_d    = 1'b0;
    tx_hold_d     = tx_hold_q;
    tx_pending_d  = tx_pending_q;
    tx_underrun_d = 1'b0;
    shift_d       = shift_q;
    frame_end_d   = 1'b0;
    di_d          = {di_q[SYNC_STAGES-2:0], spi_di};
    settle_d      = {settle_q[SYNC_STAGES-1:0], 1'b1};
    load          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && settle_q[SYNC_STAGES]) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
          first_d   = 1'b1;
          reload_d  = 1'b0;
          load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // ss_n release takes priority over any SCK edge in the same cycle
        if (ss_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          bit_cnt_d   = 3'd0;
          reload_d    = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[SPI_BITS-3:0], di_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {rx_shift_q, di_s};
            rx_strobe_d = 1'b1;
            rx_first_d  = first_q;
            first_d     = 1'b0;
            reload_d    = 1'b1;
          end
        end else if (sck_fall) begin
          if (reload_q) begin
            load     = 1'b1;
            reload_d = 1'b0;
          end else begin
            shift_d = {shift_q[SPI_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      if (tx_pending_q) begin
        shift_d      = tx_hold_q;
        tx_pending_d = 1'b0;
      end else begin
        shift_d       = FILL_BYTE;
        tx_underrun_d = 1'b1;
      end
    end

    // A write in the load cycle lands after the load: the shifter got the
    // old holding value and the new byte stays pending.
    if (tx_strobe) begin
      tx_hold_d    = tx_din;
      tx_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      first_q       <= 1'b0;
      reload_q      <= 1'b0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_strobe_q   <= 1'b0;
      rx_first_q    <= 1'b0;
      tx_hold_q     <= '0;
      tx_pending_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      shift_q       <= '1;
      frame_end_q   <= 1'b0;
      di_q          <= '0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      first_q       <= first_d;
      reload_q      <= reload_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_strobe_q   <= rx_strobe_d;
      rx_first_q    <= rx_first_d;
      tx_hold_q     <= tx_hold_d;
      tx_pending_q  <= tx_pending_d;
      tx_underrun_q <= tx_underrun_d;
      shift_q       <= shift_d;
      frame_end_q   <= frame_end_d;
      di_q          <= di_d;
      settle_q      <= settle_d;
    end
  end

  assign active      = (state_q == ST_ACTIVE);
  assign spi_do_en   = active;
  assign spi_do      = active ? shift_q[SPI_BITS-1] : 1'b1;
  assign rx_strobe   = rx_strobe_q;
  assign rx_data     = rx_data_q;
  assign rx_first    = rx_first_q;
  assign tx_pending  = tx_pending_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_end   = frame_end_q;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the SPI master (SCK = clk/8)
// and the CPU side, logs DUT pulses on the falling clk edge, and compares
// against hand-computed expectations.
module tb_spi_slave;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_di = 1'b0;
  logic       spi_do, spi_do_en;
  logic       rx_strobe, rx_first;
  logic [7:0] rx_data;
  logic       tx_strobe = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic       tx_pending, tx_underrun, active, frame_end;

  spi_slave #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_ss_n(spi_ss_n), .spi_di(spi_di),
    .spi_do(spi_do), .spi_do_en(spi_do_en), .rx_strobe(rx_strobe), .rx_data(rx_data),
    .rx_first(rx_first), .tx_strobe(tx_strobe), .tx_din(tx_din), .tx_pending(tx_pending),
    .tx_underrun(tx_underrun), .active(active), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  // Pulse logger
  logic [7:0] rx_log[$];
  bit         first_log[$];
  int         under_cnt = 0;
  int         fe_cnt = 0;
  always @(negedge clk) begin
    if (rx_strobe) begin
      rx_log.push_back(rx_data);
      first_log.push_back(rx_first);
    end
    if (tx_underrun) under_cnt++;
    if (frame_end) fe_cnt++;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_tx(input logic [7:0] v);
    @(negedge clk);
    tx_din = v;
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
  endtask

  task automatic ss_lo();
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_hi();
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Master shifts nbits MSB first; MISO sampled just before each SCK rise.
  // Optional CPU write of wv during the high phase of the 4th bit.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit do_wr,
                      input logic [7:0] wv, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      spi_di = mo[7-b];
      repeat (4) @(negedge clk);
      mi[7-b] = spi_do;
      spi_clk = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (do_wr && b == 3 && k == 0) begin
          tx_din = wv;
          tx_strobe = 1'b1;
        end else begin
          tx_strobe = 1'b0;
        end
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " spi_do"},      spi_do, 1);
    chk({tag, " spi_do_en"},   spi_do_en, 0);
    chk({tag, " rx_data"},     rx_data, 0);
    chk({tag, " rx_strobe"},   rx_strobe, 0);
    chk({tag, " rx_first"},    rx_first, 0);
    chk({tag, " tx_pending"},  tx_pending, 0);
    chk({tag, " tx_underrun"}, tx_underrun, 0);
    chk({tag, " active"},      active, 0);
    chk({tag, " frame_end"},   frame_end, 0);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_under;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] m;
    int base, u0, f0;

    // Underrun counts include the reload on the closing SCK fall of the
    // last byte, which finds the holding register empty.
    vecs[0] = '{wr: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_under: 1};
    vecs[1] = '{wr: 1'b0, tx: 8'h00, mosi: 8'hC3, exp_miso: 8'hFF, exp_under: 2};
    vecs[2] = '{wr: 1'b1, tx: 8'h00, mosi: 8'hFF, exp_miso: 8'h00, exp_under: 1};
    vecs[3] = '{wr: 1'b1, tx: 8'h81, mosi: 8'h7E, exp_miso: 8'h81, exp_under: 1};

    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Single-byte frames
    for (int v = 0; v < 4; v++) begin
      base = rx_log.size(); u0 = under_cnt; f0 = fe_cnt;
      if (vecs[v].wr) write_tx(vecs[v].tx);
      chk($sformatf("v%0d pend_pre", v), tx_pending, vecs[v].wr);
      ss_lo();
      chk($sformatf("v%0d active", v), active, 1);
      chk($sformatf("v%0d pend_ss", v), tx_pending, 0);
      xfer(vecs[v].mosi, 8, 1'b0, 8'h00, m);
      chk($sformatf("v%0d miso", v), m, vecs[v].exp_miso);
      ss_hi();
      chk($sformatf("v%0d rx_cnt", v), rx_log.size() - base, 1);
      if (rx_log.size() > base) begin
        chk($sformatf("v%0d rx_data", v), rx_log[base], vecs[v].mosi);
        chk($sformatf("v%0d rx_first", v), first_log[base], 1);
      end
      chk($sformatf("v%0d underrun", v), under_cnt - u0, vecs[v].exp_under);
      chk($sformatf("v%0d frame_end", v), fe_cnt - f0, 1);
      chk($sformatf("v%0d idle", v), active, 0);
    end

    // 3-byte frame, nothing written: FF out, first flag only on byte 0
    base = rx_log.size(); u0 = under_cnt;
    ss_lo();
    for (int i = 0; i < 3; i++) begin
      xfer(8'(i + 1), 8, 1'b0, 8'h00, m);
      chk($sformatf("multi miso%0d", i), m, 8'hFF);
    end
    ss_hi();
    chk("multi rx_cnt", rx_log.size() - base, 3);
    if (rx_log.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("multi rx%0d", i), rx_log[base+i], i + 1);
        chk($sformatf("multi first%0d", i), first_log[base+i], (i == 0) ? 1 : 0);
      end
    end
    chk("multi underrun", under_cnt - u0, 4);

    // Write during byte 0 feeds byte 1
    write_tx(8'h11);
    ss_lo();
    xfer(8'h00, 8, 1'b1, 8'h22, m);
    chk("wr_mid miso0", m, 8'h11);
    xfer(8'h00, 8, 1'b0, 8'h00, m);
    chk("wr_mid miso1", m, 8'h22);
    ss_hi();
    chk("wr_mid pend", tx_pending, 0);

    // Write in the same cycle as the ss_n-fall load
    write_tx(8'h44);
    @(negedge clk);
    spi_ss_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tx_din = 8'h33;
    tx_strobe = 1'b1;
    @(negedge clk);
    tx_strobe = 1'b0;
    chk("same_cyc active", active, 1);
    chk("same_cyc pend", tx_pending, 1);
    repeat (6) @(negedge clk);
    xfer(8'h00, 8, 1'b0, 8'h00, m);
    chk("same_cyc miso0", m, 8'h44);
    xfer(8'h00, 8, 1'b0, 8'h00, m);
    chk("same_cyc miso1", m, 8'h33);
    ss_hi();
    chk("same_cyc pend_end", tx_pending, 0);

    // Abort after 5 SCK rises, then a clean frame
    base = rx_log.size(); f0 = fe_cnt;
    ss_lo();
    xfer(8'hF0, 5, 1'b0, 8'h00, m);
    ss_hi();
    chk("abort rx_cnt", rx_log.size() - base, 0);
    chk("abort frame_end", fe_cnt - f0, 1);
    chk("abort do_en", spi_do_en, 0);
    chk("abort do", spi_do, 1);
    ss_lo();
    xfer(8'h5A, 8, 1'b0, 8'h00, m);
    ss_hi();
    chk("abort next rx_cnt", rx_log.size() - base, 1);
    if (rx_log.size() > base) begin
      chk("abort next rx", rx_log[base], 8'h5A);
      chk("abort next first", first_log[base], 1);
    end

    // Reset mid-byte with ss_n held low
    ss_lo();
    xfer(8'hE0, 3, 1'b0, 8'h00, m);
    write_tx(8'h99);
    chk("rst pend_pre", tx_pending, 1);
    chk("rst active_pre", active, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    base = rx_log.size();
    repeat (6) @(negedge clk);
    xfer(8'hAA, 8, 1'b0, 8'h00, m);
    repeat (6) @(negedge clk);
    chk("rst no_rx", rx_log.size() - base, 0);
    chk("rst no_active", active, 0);
    ss_hi();
    ss_lo();
    xfer(8'h77, 8, 1'b0, 8'h00, m);
    ss_hi();
    chk("rst resume rx_cnt", rx_log.size() - base, 1);
    if (rx_log.size() > base) chk("rst resume rx", rx_log[base], 8'h77);

    // SCK toggling with ss_n high
    write_tx(8'h6B);
    base = rx_log.size();
    xfer(8'h55, 8, 1'b0, 8'h00, m);
    chk("idle_sck do", m, 8'hFF);
    xfer(8'hAA, 8, 1'b0, 8'h00, m);
    repeat (6) @(negedge clk);
    chk("idle_sck rx", rx_log.size() - base, 0);
    chk("idle_sck do_en", spi_do_en, 0);
    chk("idle_sck pend", tx_pending, 1);
    ss_lo();
    xfer(8'h00, 8, 1'b0, 8'h00, m);
    chk("idle_sck then miso", m, 8'h6B);
    ss_hi();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, limit 2000000 time units");
    $fatal(1);
  end
endmodule
